multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the cs161 MIPS-subset datapath. It replaces the single-cycle control path by stepping each instruction through FETCH/DECODE/EXECUTE/MEM/WB states. The shared cpumemory serves both instruction and data accesses, and each access is stalled on a ready handshake. It emits every datapath mux select and write strobe, and counts retired instructions.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter
STATE_WIDTH, 4, width of state encoding exported on state_out

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr_op  in  6  opcode field inst[31:26] from the instruction register
mem_ready  in  1  memory has completed the current access this cycle
alu_zero  in  1  ALU zero flag
mem_req  out  1  memory access in progress
iord  out  1  0 = PC addresses memory, 1 = ALU-out addresses memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if alu_zero
pc_source  out  2  0 = ALU result, 1 = ALU-out register (branch target), 2 = jump target
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  0 = reg B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded (to alu_control)
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALU-out, 1 = memory data register
reg_write  out  1  register file write strobe
illegal_instr  out  1  one-cycle pulse on unsupported opcode
state_out  out  STATE_WIDTH  current state, for debug
retired_count  out  COUNT_WIDTH  instructions completed since reset

Behaviour:
- Opcodes: RTYPE 0x00, LW 0x23, SW 0x2B, BEQ 0x04, ADDI 0x08, J 0x02.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- Reset: synchronous. On the next edge state=FETCH and retired_count=0. While rst=1, all strobes (mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal_instr) are forced to 0 combinationally. Asserting rst in any state aborts that state with no further writes.
- Outputs are combinational decodes of the state. ir_write and pc_write in FETCH are additionally gated by mem_ready.
- FETCH: mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. ir_write=pc_write=mem_ready. Stay while mem_ready=0; on mem_ready=1 go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (precomputes branch target). Dispatch on instr_op:
  - LW/SW -> MEM_ADDR
  - RTYPE -> EXEC_R
  - ADDI -> EXEC_I
  - BEQ -> BRANCH
  - J -> JUMP
  - any other opcode -> FETCH with illegal_instr=1 for that cycle; not counted as retired.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Go to MEM_RD if LW, MEM_WR if SW.
- MEM_RD: mem_req=1, mem_read=1, iord=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR: mem_req=1, mem_write=1, iord=1. Hold until mem_ready, then go to FETCH. mem_write stays high for the whole wait; memory commits once, on the ready cycle.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=0 -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1 -> FETCH.
- JUMP: pc_write=1, pc_source=2 -> FETCH.
- Latency with mem_ready always 1:
  - R-type = 4 cycles
  - ADDI = 4 cycles
  - LW = 5 cycles
  - SW = 4 cycles
  - BEQ = 3 cycles
  - J = 3 cycles
  - Each cycle of mem_ready=0 adds one cycle.
- retired_count increments by 1 on each transition into FETCH from MEM_WB, R_WB, I_WB, BRANCH, or JUMP, and from MEM_WR when mem_ready=1. It wraps modulo 2^COUNT_WIDTH.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Unused state encodings go to FETCH on the next edge with no strobes.

Decomposition:
- Shared package cs161_pkg: opcode constants, state encoding constants, alu_op and alu_src_b and pc_source encodings.
- One sub-module, multicycle_ctrl_decode: combinational state-to-control-word decode.
- FSM register and counter remain in the top.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with mem_ready=1. Strobes must be 0 throughout. After release, state_out=FETCH and retired_count=0.
2. R-type, instr_op=0x00, mem_ready=1: state sequence FETCH,DECODE,EXEC_R,R_WB; reg_write=1 and reg_dst=1 in cycle 4; retired_count becomes 1.
3. LW, instr_op=0x23, with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD: total 10 cycles; ir_write pulses exactly once; reg_write with mem_to_reg=1 exactly once.
4. BEQ, instr_op=0x04: 3 cycles; in BRANCH, pc_write_cond=1, pc_source=1, alu_op=1; retired_count increments whether alu_zero is 0 or 1.
5. Illegal opcode, instr_op=0x3F: FETCH,DECODE,FETCH; illegal_instr is a one-cycle pulse in DECODE; retired_count unchanged.
6. Abort and wrap:
   - rst asserted mid MEM_WR with mem_ready=0: mem_write drops the same cycle and state is FETCH after the edge.
   - Counter wrap, COUNT_WIDTH=4: 16 J instructions return retired_count to 0.

Source files
------------

// File: rtl/cs161_pkg.sv
// Shared definitions for the cs161 multi-cycle controller: opcodes,
// FSM state encoding, datapath mux encodings and the control word.
package cs161_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_REG_B   = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU     = 2'd0;
    localparam logic [1:0] PCSRC_ALU_OUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP    = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_instr;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of the FSM state into the datapath control word.
module multicycle_ctrl_decode
    import cs161_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Every field defaults to 0 so unused encodings drive no strobes
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC only update once the instruction word has arrived
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            ST_DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched
                ctrl_o.alu_src_b     = SRCB_IMM_SH2;
                ctrl_o.alu_op        = ALU_OP_ADD;
                ctrl_o.illegal_instr = !is_legal_op(instr_op_i);
            end
            ST_MEM_ADDR, ST_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG_B;
                ctrl_o.alu_op    = ALU_OP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            ST_I_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG_B;
                ctrl_o.alu_op        = ALU_OP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALU_OUT;
            end
            ST_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the cs161 MIPS-subset datapath: state
// register, next-state dispatch and retired-instruction counter.
module multicycle_ctrl
    import cs161_pkg::*;
#(
    parameter int COUNT_WIDTH = 32,
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             instr_op,
    input  logic                   mem_ready,
    input  logic                   alu_zero,
    output logic                   mem_req,
    output logic                   iord,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_source,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   illegal_instr,
    output logic [STATE_WIDTH-1:0] state_out,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    state_e                 state_q, state_d;
    logic                   retire_d;
    logic [COUNT_WIDTH-1:0] count_q;
    ctrl_t                  ctrl;

    // Branch resolution happens in the datapath (pc_write_cond & alu_zero)
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    multicycle_ctrl_decode u_decode (
        .state_i     (state_q),
        .instr_op_i  (instr_op),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Next state and retirement: an instruction retires on its last state
    always_comb begin
        state_d  = ST_FETCH;
        retire_d = 1'b0;
        case (state_q)
            ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (instr_op)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_d = (instr_op == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WR: begin
                state_d  = mem_ready ? ST_FETCH : ST_MEM_WR;
                retire_d = mem_ready;
            end
            ST_EXEC_R:   state_d = ST_R_WB;
            ST_EXEC_I:   state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: begin
                state_d  = ST_FETCH;
                retire_d = 1'b1;
            end
            default:     state_d = ST_FETCH;
        endcase
    end

    // State register and wrapping retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_d) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Strobes are killed immediately by reset so an aborted access never commits
    assign mem_req       = ctrl.mem_req       & ~rst;
    assign mem_read      = ctrl.mem_read      & ~rst;
    assign mem_write     = ctrl.mem_write     & ~rst;
    assign ir_write      = ctrl.ir_write      & ~rst;
    assign pc_write      = ctrl.pc_write      & ~rst;
    assign pc_write_cond = ctrl.pc_write_cond & ~rst;
    assign reg_write     = ctrl.reg_write     & ~rst;
    assign illegal_instr = ctrl.illegal_instr & ~rst;

    assign iord       = ctrl.iord;
    assign pc_source  = ctrl.pc_source;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;

    assign state_out     = STATE_WIDTH'(state_q);
    assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected state
// traces built from the instruction-class rules, random memory wait states.
module tb_multicycle_ctrl;
    import cs161_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    instr_op;
    logic          mem_ready;
    logic          alu_zero;
    logic          mem_req, iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
    logic [1:0]    pc_source, alu_src_b, alu_op;
    logic          alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_instr;
    logic [3:0]    state_out;
    logic [CW-1:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_retired = 0;
    int n_ir, n_rw_mem, n_ill, n_memwr;

    always #5 clk = ~clk;

    multicycle_ctrl #(.COUNT_WIDTH(CW), .STATE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .mem_req(mem_req), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_instr(illegal_instr), .state_out(state_out), .retired_count(retired_count)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    // Expected {mem_req,mem_read,mem_write,ir_write,pc_write,pc_write_cond,reg_write,illegal}
    function automatic logic [7:0] exp_strobes(input logic [3:0] s, input logic rdy, input logic [5:0] op);
        logic fetch_done;
        fetch_done = (s == ST_FETCH) && rdy;
        return {s inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR},
                s inside {ST_FETCH, ST_MEM_RD},
                s == ST_MEM_WR,
                fetch_done,
                fetch_done || (s == ST_JUMP),
                s == ST_BRANCH,
                s inside {ST_MEM_WB, ST_R_WB, ST_I_WB},
                (s == ST_DECODE) && !legal(op)};
    endfunction

    // Returns {care[9:0], value[9:0]} for {iord,alu_src_a,alu_src_b,alu_op,pc_source,reg_dst,mem_to_reg}
    function automatic logic [19:0] exp_mux(input logic [3:0] s);
        logic [9:0] v, c;
        v = '0; c = '0;
        case (s)
            ST_FETCH:              begin v = {1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'b00}; c = 10'b1111111100; end
            ST_DECODE:             begin v = {1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 2'b00}; c = 10'b0111110000; end
            ST_MEM_ADDR, ST_EXEC_I:begin v = {1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 2'b00}; c = 10'b0111110000; end
            ST_MEM_RD, ST_MEM_WR:  begin v = {1'b1, 9'd0};                          c = 10'b1000000000; end
            ST_MEM_WB:             begin v = 10'b0000000001;                        c = 10'b0000000011; end
            ST_EXEC_R:             begin v = {1'b0, 1'b1, 2'd0, 2'd2, 2'd0, 2'b00}; c = 10'b0111110000; end
            ST_R_WB:               begin v = 10'b0000000010;                        c = 10'b0000000011; end
            ST_I_WB:               begin v = 10'b0000000000;                        c = 10'b0000000011; end
            ST_BRANCH:             begin v = {1'b0, 1'b1, 2'd0, 2'd1, 2'd1, 2'b00}; c = 10'b0111111100; end
            ST_JUMP:               begin v = {6'd0, 2'd2, 2'b00};                   c = 10'b0000001100; end
            default: ;
        endcase
        return {c, v};
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait, input logic z);
        logic [3:0] seq[$];
        logic [7:0] es, as;
        logic [19:0] em;
        logic [9:0] am;
        seq = {};
        repeat (fwait + 1) seq.push_back(ST_FETCH);
        seq.push_back(ST_DECODE);
        case (op)
            6'h23: begin seq.push_back(ST_MEM_ADDR); repeat (mwait + 1) seq.push_back(ST_MEM_RD); seq.push_back(ST_MEM_WB); end
            6'h2B: begin seq.push_back(ST_MEM_ADDR); repeat (mwait + 1) seq.push_back(ST_MEM_WR); end
            6'h00: begin seq.push_back(ST_EXEC_R); seq.push_back(ST_R_WB); end
            6'h08: begin seq.push_back(ST_EXEC_I); seq.push_back(ST_I_WB); end
            6'h04: seq.push_back(ST_BRANCH);
            6'h02: seq.push_back(ST_JUMP);
            default: ;
        endcase
        n_ir = 0; n_rw_mem = 0; n_ill = 0; n_memwr = 0;
        for (int i = 0; i < seq.size(); i++) begin
            logic last, rdy;
            last = (i == seq.size() - 1) || (seq[i + 1] != seq[i]);
            @(negedge clk);
            rdy = (seq[i] inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR}) ? last : 1'($urandom_range(0, 1));
            mem_ready = rdy;
            instr_op  = op;
            alu_zero  = z;
            #1;
            n_checks++;
            if (state_out !== seq[i]) begin
                n_fail++;
                $display("FAIL state op=%h cyc=%0d: got %0d expected %0d", op, i, state_out, seq[i]);
            end
            es = exp_strobes(seq[i], rdy, op);
            as = {mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal_instr};
            n_checks++;
            if (as !== es) begin
                n_fail++;
                $display("FAIL strobes op=%h cyc=%0d: got %b expected %b", op, i, as, es);
            end
            em = exp_mux(seq[i]);
            am = {iord, alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg};
            n_checks++;
            if ((am & em[19:10]) !== (em[9:0] & em[19:10])) begin
                n_fail++;
                $display("FAIL muxes op=%h cyc=%0d: got %b expected %b care %b", op, i, am, em[9:0], em[19:10]);
            end
            n_ir     += int'(ir_write);
            n_rw_mem += int'(reg_write && mem_to_reg);
            n_ill    += int'(illegal_instr);
            n_memwr  += int'(mem_write);
        end
        if (legal(op)) exp_retired = (exp_retired + 1) % (1 << CW);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        n_checks++;
        if (state_out !== ST_FETCH || retired_count !== CW'(exp_retired)) begin
            n_fail++;
            $display("FAIL retire op=%h: state %0d count %0d expected state %0d count %0d",
                     op, state_out, retired_count, ST_FETCH, exp_retired);
        end
        $display("instr op=%h fwait=%0d mwait=%0d cycles=%0d retired=%0d", op, fwait, mwait, seq.size(), retired_count);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; instr_op = 6'h23; alu_zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal_instr} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_strobes cyc=%0d: got %b expected 00000000", i,
                         {mem_req, mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, illegal_instr});
            end
        end
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_out !== ST_FETCH || retired_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: state %0d count %0d expected %0d and 0", state_out, retired_count, ST_FETCH);
        end
        exp_retired = 0;
        $display("reset done state=%0d retired=%0d", state_out, retired_count);
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 0, 0, 1'b0);
        run_instr(6'h08, 1, 0, 1'b1);
    endtask

    task automatic test_lw();
        run_instr(6'h23, 2, 3, 1'b0);
        n_checks++;
        if (n_ir != 1 || n_rw_mem != 1) begin
            n_fail++;
            $display("FAIL lw_pulses: ir_write %0d reg_write&mem_to_reg %0d expected 1 and 1", n_ir, n_rw_mem);
        end
        run_instr(6'h2B, 0, 2, 1'b0);
        n_checks++;
        if (n_memwr != 3) begin
            n_fail++;
            $display("FAIL sw_write_cycles: got %0d expected 3", n_memwr);
        end
    endtask

    task automatic test_beq();
        run_instr(6'h04, 0, 0, 1'b0);
        run_instr(6'h04, 0, 0, 1'b1);
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 0, 0, 1'b0);
        n_checks++;
        if (n_ill != 1) begin
            n_fail++;
            $display("FAIL illegal_pulse: got %0d cycles expected 1", n_ill);
        end
    endtask

    task automatic test_abort();
        logic [3:0] pre[4];
        pre = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            instr_op  = 6'h2B;
            mem_ready = (i == 0);
            #1;
            n_checks++;
            if (state_out !== pre[i]) begin
                n_fail++;
                $display("FAIL abort_seq cyc=%0d: got %0d expected %0d", i, state_out, pre[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (mem_write !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_strobe: mem_write %b mem_req %b expected 0 0", mem_write, mem_req);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (state_out !== ST_FETCH || retired_count !== '0) begin
            n_fail++;
            $display("FAIL abort_state: state %0d count %0d expected %0d and 0", state_out, retired_count, ST_FETCH);
        end
        exp_retired = 0;
        @(negedge clk);
        rst = 1'b0;
        $display("abort in MEM_WR state=%0d retired=%0d", state_out, retired_count);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) run_instr(6'h02, 0, 0, 1'($urandom_range(0, 1)));
        n_checks++;
        if (retired_count !== '0) begin
            n_fail++;
            $display("FAIL wrap: got %0d expected 0", retired_count);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[6];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_illegal();
        test_abort();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
